// File: rtl/fetch_controller_if.sv
// fetch_controller_if: instruction-memory fetch handshake between fetch_controller and imem.
interface fetch_controller_if #(parameter int ADDR_W = 6);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  modport master (output imem_req, output imem_addr, input imem_ack);
  modport slave (input imem_req, input imem_addr, output imem_ack);
endinterface

// File: rtl/fetch_controller.sv
// fetch_controller: PC sequencer with req/ack fetch, stall, redirect and halt; PC_WRAP_HALT_EN halts after fetching the last address.
module fetch_controller #(
  parameter int              ADDR_W    = 6,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              halt_req,
  fetch_controller_if.master imem,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc_out,
  output logic              halted,
  output logic [15:0]       fetch_count
);
  typedef enum logic [1:0] {IDLE, FETCH, STALL, HALT} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_out_q, pc_out_d;
  logic              valid_q, valid_d, req_q, halted_q;
  logic [15:0]       cnt_q, cnt_d;
  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign instr_valid    = valid_q;
  assign pc_out         = pc_out_q;
  assign halted         = halted_q;
  assign fetch_count    = cnt_q;
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    valid_d  = 1'b0;
    pc_out_d = pc_out_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE:
        if (halt_req) state_d = HALT;
        else if (start) begin
          state_d = FETCH;
          pc_d    = RESET_VEC;
        end
      FETCH:
        if (halt_req) state_d = HALT;
        else if (redirect) pc_d = redirect_addr;
        else if (stall) state_d = STALL;
        else if (imem.imem_ack) begin
          valid_d  = 1'b1;
          pc_out_d = pc_q;
          pc_d     = pc_q + ADDR_W'(1);
          cnt_d    = cnt_q + 16'd1;
`ifdef PC_WRAP_HALT_EN
          if (&pc_q) begin
            pc_d    = pc_q;
            state_d = HALT;
          end
`endif
        end
      STALL:
        if (halt_req) state_d = HALT;
        else if (redirect) begin
          pc_d    = redirect_addr;
          state_d = stall ? STALL : FETCH;
        end else if (!stall) state_d = FETCH;
      default: ;
    endcase
  end
  // req/halted are registered copies of the next-state decode, so they track state exactly
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= RESET_VEC;
      pc_out_q <= '0;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
      req_q    <= (state_d == FETCH);
      halted_q <= (state_d == HALT);
    end
  end
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed stimulus with an expected-pc_out scoreboard for fetch_controller.
module tb_fetch_controller;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, stall = 1'b0, redirect = 1'b0, halt_req = 1'b0;
  logic [5:0]  redirect_addr = '0, pc_out;
  logic        instr_valid, halted;
  logic [15:0] fetch_count;
  int          tests = 0, fails = 0;
  int          exp_q[$];
  fetch_controller_if #(.ADDR_W(6)) bus ();
  fetch_controller #(.ADDR_W(6), .RESET_VEC(6'd0)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .redirect(redirect),
    .redirect_addr(redirect_addr), .halt_req(halt_req), .imem(bus.master),
    .instr_valid(instr_valid), .pc_out(pc_out), .halted(halted), .fetch_count(fetch_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic cyc(input int acc);
    int e;
    if (acc >= 0) exp_q.push_back(acc);
    @(posedge clk);
    #1;
    chk("instr_valid", 32'(instr_valid), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pc_out", 32'(pc_out), e);
    end
  endtask
  task automatic go(input logic [5:0] a);
    redirect = 1'b1;
    redirect_addr = a;
    cyc(-1);
    redirect = 1'b0;
  endtask
  initial begin
    bus.imem_ack = 1'b0;
    cyc(-1);
    cyc(-1);
    reset = 1'b0;
    chk("rst_req", 32'(bus.imem_req), 0);
    chk("rst_addr", 32'(bus.imem_addr), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_pc_out", 32'(pc_out), 0);
    chk("rst_count", 32'(fetch_count), 0);
    cyc(-1);
    chk("idle_req", 32'(bus.imem_req), 0);
    start = 1'b1;
    cyc(-1);
    start = 1'b0;
    chk("start_req", 32'(bus.imem_req), 1);
    bus.imem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("zw_addr", 32'(bus.imem_addr), i);
      cyc(i);
    end
    bus.imem_ack = 1'b0;
    chk("zw_count", 32'(fetch_count), 4);
    cyc(-1);
    bus.imem_ack = 1'b1;
    cyc(4);
    bus.imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("wait_req", 32'(bus.imem_req), 1);
      chk("wait_addr", 32'(bus.imem_addr), 5);
      cyc(-1);
    end
    bus.imem_ack = 1'b1;
    cyc(5);
    bus.imem_ack = 1'b0;
    chk("wait_next", 32'(bus.imem_addr), 6);
    chk("wait_count", 32'(fetch_count), 6);
    bus.imem_ack = 1'b1;
    for (int i = 6; i < 10; i++) cyc(i);
    chk("pre_redir", 32'(bus.imem_addr), 10);
    go(6'd40);
    bus.imem_ack = 1'b0;
    chk("redir_addr", 32'(bus.imem_addr), 40);
    chk("redir_count", 32'(fetch_count), 10);
    go(6'd7);
    stall = 1'b1;
    bus.imem_ack = 1'b1;
    cyc(-1);
    chk("stall_req", 32'(bus.imem_req), 0);
    chk("stall_addr", 32'(bus.imem_addr), 7);
    cyc(-1);
    chk("stall_req2", 32'(bus.imem_req), 0);
    stall = 1'b0;
    cyc(-1);
    chk("unstall_req", 32'(bus.imem_req), 1);
    chk("unstall_addr", 32'(bus.imem_addr), 7);
    cyc(7);
    bus.imem_ack = 1'b0;
    chk("stall_next", 32'(bus.imem_addr), 8);
    chk("stall_count", 32'(fetch_count), 11);
    go(6'd12);
    halt_req = 1'b1;
    bus.imem_ack = 1'b1;
    cyc(-1);
    halt_req = 1'b0;
    chk("halt_halted", 32'(halted), 1);
    chk("halt_req", 32'(bus.imem_req), 0);
    chk("halt_count", 32'(fetch_count), 11);
    for (int i = 0; i < 3; i++) begin
      start = i[0];
      bus.imem_ack = ~i[0];
      cyc(-1);
      chk("halt_stay", 32'(halted), 1);
      chk("halt_addr", 32'(bus.imem_addr), 12);
    end
    start = 1'b0;
    reset = 1'b1;
    bus.imem_ack = 1'b1;
    cyc(-1);
    reset = 1'b0;
    bus.imem_ack = 1'b0;
    chk("rst2_halted", 32'(halted), 0);
    chk("rst2_req", 32'(bus.imem_req), 0);
    chk("rst2_addr", 32'(bus.imem_addr), 0);
    chk("rst2_count", 32'(fetch_count), 0);
    start = 1'b1;
    cyc(-1);
    start = 1'b0;
    go(6'd63);
    bus.imem_ack = 1'b1;
    cyc(63);
    bus.imem_ack = 1'b0;
    chk("wrap_count", 32'(fetch_count), 1);
`ifdef PC_WRAP_HALT_EN
    chk("wrap_halted", 32'(halted), 1);
    chk("wrap_req", 32'(bus.imem_req), 0);
    chk("wrap_addr", 32'(bus.imem_addr), 63);
`else
    chk("wrap_halted", 32'(halted), 0);
    chk("wrap_req", 32'(bus.imem_req), 1);
    chk("wrap_addr", 32'(bus.imem_addr), 0);
`endif
    cyc(-1);
    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fetch_controller.md
# fetch_controller

Sequencer for the CPU's program counter and instruction-memory fetch port. Holds the architectural PC, issues fetch requests to instruction memory with a request/acknowledge handshake, and applies increment, stall, branch/jump redirect and halt decisions from the pipeline. Sits between the decode/execute control logic and the instruction memory, replacing free-running PC increment with a controlled fetch schedule.

## Interface
- ADDR_W, 6, width of PC and instruction address
- RESET_VEC, 0, PC value loaded on reset and on start
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  leave IDLE and begin fetching at RESET_VEC
- stall  input  1  pipeline hazard; hold PC and suspend fetching
- redirect  input  1  taken branch/jump this cycle
- redirect_addr  input  ADDR_W  target of redirect
- halt_req  input  1  stop fetching permanently until reset
- imem_req  output  1  fetch request, high only in FETCH
- imem_addr  output  ADDR_W  current PC register
- imem_ack  input  1  memory accepts/returns instruction this cycle
- instr_valid  output  1  registered one-cycle pulse per accepted fetch
- pc_out  output  ADDR_W  address of the instruction flagged by instr_valid
- halted  output  1  high in HALT
- fetch_count  output  16  accepted fetches since reset, wraps at 65535→0

## Operation
- Clock is clk; reset is synchronous and active-high on reset.
- States: IDLE, FETCH, STALL, HALT. Outputs imem_req, halted decoded from state only (Moore).
- Priority each cycle: reset > halt_req > redirect > stall > imem_ack.
- IDLE: halt_req → HALT; start → FETCH, pc ← RESET_VEC; else hold.
- FETCH: halt_req → HALT, ack ignored. redirect → pc ← redirect_addr, stay FETCH, ack squashed. stall → STALL, pc held, ack ignored (request reissued later). imem_ack alone → accepted: instr_valid←1, pc_out←pc, pc←pc+1 (mod 2^ADDR_W), fetch_count+1.
- STALL: halt_req → HALT; redirect → pc ← redirect_addr, stay STALL if stall else FETCH; stall low → FETCH.
- HALT: absorbing; only reset exits. imem_ack ignored.
- imem_addr always equals pc register; memory must only sample it when imem_req=1.
- Accepted fetch = state FETCH & imem_ack & !halt_req & !redirect & !stall.

## Timing
- Reset values: state IDLE, pc=RESET_VEC, imem_req=0, imem_addr=RESET_VEC, instr_valid=0, pc_out=0, halted=0, fetch_count=0.
- Reset mid-fetch: imem_req drops the cycle after reset is sampled; an ack in the reset cycle is ignored.
- start sampled in IDLE: imem_req=1 from next cycle.
- Zero-wait memory (ack tied high): one accepted fetch per cycle, pc increments each cycle.
- instr_valid/pc_out latency: 1 cycle after the accepting edge; instr_valid low in every cycle not following an acceptance.
- Redirect: imem_addr=redirect_addr the cycle after redirect; no instr_valid for the squashed address.
- Wrap: pc=2^ADDR_W-1 accepted → pc=0 (unless PC_WRAP_HALT_EN).
- fetch_count increments in the same edge as pc advance.

## Configuration
- PC_WRAP_HALT_EN defined: an accepted fetch at pc=2^ADDR_W-1 without redirect still delivers instr_valid/pc_out for that address, then enters HALT (pc stays 2^ADDR_W-1, halted=1 next cycle).
- Not defined: pc wraps to 0, state remains FETCH.

## Test plan
- Reset then start, ack tied high 4 cycles → imem_addr 0,1,2,3; instr_valid pulses with pc_out 0,1,2,3 one cycle later; fetch_count=4.
- Ack delayed 3 cycles at pc=5 → imem_req held, imem_addr=5 stable, single instr_valid with pc_out=5, then imem_addr=6.
- redirect=1, redirect_addr=40 with simultaneous ack at pc=10 → no instr_valid for 10, next imem_addr=40, fetch_count unchanged.
- stall with ack at pc=7 for 2 cycles → imem_req=0 during STALL, pc=7 held; after release fetch of 7 reissued and delivered once.
- halt_req during FETCH at pc=12 → halted=1, imem_req=0 next cycle, stays halted with start/ack toggling; reset → IDLE, pc=0.
- pc=63, ack → without macro imem_addr=0 next; with PC_WRAP_HALT_EN pc_out=63 valid then halted=1.
